// File: rtl/float_addsub_pipe.sv
// float_addsub_pipe: 3-stage IEEE-754 add/sub with RNE rounding, special cases, flags and valid/ready.
// Define FADD_SUBNORMAL_EN for gradual underflow; the default build flushes subnormals to zero.
module float_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         nan_flag,
    output logic         overflow_flag,
    output logic         underflow_flag,
    output logic         inexact_flag
);

    localparam int F    = MAN_W + 4;
    localparam int S    = MAN_W + 5;
    localparam int E1   = EXP_W + 1;
    localparam int LZ_W = $clog2(MAN_W + 5);
    localparam int SA_W = $clog2(MAN_W + 4);
    localparam int CW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
`ifdef FADD_SUBNORMAL_EN
    localparam bit SUBN = 1'b1;
`else
    localparam bit SUBN = 1'b0;
`endif

    function automatic logic [LZ_W-1:0] lzc(input logic [F-1:0] v);
        lzc = LZ_W'(F);
        for (int i = 0; i < F; i++)
            if (v[i]) lzc = LZ_W'(F - 1 - i);
    endfunction

    // Right shift into {hidden, fraction, g, r, s}; everything shifted past s is ORed into it.
    function automatic logic [F-1:0] align(input logic [MAN_W:0] sig, input logic [SA_W-1:0] sh);
        logic [2*F-1:0] ext;
        ext   = {sig, 3'b000, {F{1'b0}}} >> sh;
        align = ext[2*F-1:F] | {{(F-1){1'b0}}, |ext[F-1:0]};
    endfunction

    // Returns {rounded {exp, frac}, inexact}; a mantissa carry ripples into the exponent.
    function automatic logic [E1+MAN_W:0] rne(input logic [E1-1:0] e, input logic [F-1:0] n);
        logic inc;
        inc = n[2] & (n[1] | n[0] | n[3]);
        rne = {({e, n[F-2:3]} + (E1+MAN_W)'(inc)), (n[2] | n[1] | n[0])};
    endfunction

    logic w_stall;
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // ---- stage 1: unpack, classify, swap, align ----
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb, w_xa, w_xb, w_xbig, w_xsml, w_diff;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [MAN_W:0]   w_ma, w_mb, w_mbig, w_msml;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_ge;
    logic [SA_W-1:0]  w_sh1;

    assign {w_sa, w_ea, w_fa} = a;
    assign w_sb    = b[W-1] ^ sub;
    assign w_eb    = b[W-2:MAN_W];
    assign w_fb    = b[MAN_W-1:0];
    assign w_a_nan = (&w_ea) & (|w_fa);
    assign w_b_nan = (&w_eb) & (|w_fb);
    assign w_a_inf = (&w_ea) & ~(|w_fa);
    assign w_b_inf = (&w_eb) & ~(|w_fb);
    assign w_xa    = (w_ea == '0) ? EXP_W'(SUBN) : w_ea;
    assign w_xb    = (w_eb == '0) ? EXP_W'(SUBN) : w_eb;
    assign w_ma    = (w_ea == '0) ? (SUBN ? {1'b0, w_fa} : '0) : {1'b1, w_fa};
    assign w_mb    = (w_eb == '0) ? (SUBN ? {1'b0, w_fb} : '0) : {1'b1, w_fb};
    assign w_a_ge  = {w_xa, w_ma} >= {w_xb, w_mb};
    assign w_xbig  = w_a_ge ? w_xa : w_xb;
    assign w_xsml  = w_a_ge ? w_xb : w_xa;
    assign w_mbig  = w_a_ge ? w_ma : w_mb;
    assign w_msml  = w_a_ge ? w_mb : w_ma;
    assign w_diff  = w_xbig - w_xsml;
    assign w_sh1   = (w_diff > EXP_W'(MAN_W + 3)) ? SA_W'(MAN_W + 3) : w_diff[SA_W-1:0];

    logic             r_vld_p1, r_s_p1, r_sub_p1, r_nan_p1, r_inf_p1, r_infs_p1, r_zs_p1;
    logic [EXP_W-1:0] r_e_p1;
    logic [MAN_W:0]   r_mbig_p1;
    logic [F-1:0]     r_msml_p1;

    // ---- stage 2: significand add/subtract ----
    logic [S-1:0] w_sum;
    assign w_sum = r_sub_p1 ? ({1'b0, r_mbig_p1, 3'b000} - {1'b0, r_msml_p1})
                            : ({1'b0, r_mbig_p1, 3'b000} + {1'b0, r_msml_p1});

    logic             r_vld_p2, r_s_p2, r_nan_p2, r_inf_p2, r_infs_p2, r_zs_p2;
    logic [EXP_W-1:0] r_e_p2;
    logic [S-1:0]     r_sum_p2;

    // ---- stage 3: normalise, round, special-case override ----
    logic [LZ_W-1:0]   w_lz;
    logic [CW-1:0]     w_lzc, w_ec, w_sh3;
    logic [E1-1:0]     w_en;
    logic [F-1:0]      w_n;
    logic [E1+MAN_W:0] w_rnd;
    logic              w_tiny, w_ovf;
    logic [W-1:0]      w_res;
    logic              w_nan, w_of, w_uf, w_ix;

    always_comb begin
        w_lz  = lzc(r_sum_p2[F-1:0]);
        w_lzc = CW'(w_lz);
        w_ec  = CW'(r_e_p2);
        w_sh3 = '0;
        w_en  = '0;
        w_n   = '0;
        if (r_sum_p2[S-1]) begin
            w_n  = {r_sum_p2[S-1:2], |r_sum_p2[1:0]};
            w_en = E1'(r_e_p2) + E1'(1);
        end else begin
            if (w_lzc < w_ec) begin
                w_sh3 = w_lzc;
                w_en  = E1'(w_ec - w_lzc);
            end else if (w_ec != '0) begin
                w_sh3 = w_ec - CW'(1);
            end
            w_n = r_sum_p2[F-1:0] << w_sh3;
        end
        w_rnd  = rne(w_en, w_n);
        w_tiny = ~w_n[F-1];
        w_ovf  = w_rnd[E1+MAN_W:MAN_W+1] >= E1'({EXP_W{1'b1}});

        w_res = {r_s_p2, w_rnd[EXP_W+MAN_W:1]};
        w_nan = 1'b0;
        w_of  = 1'b0;
        w_uf  = SUBN & w_tiny & w_rnd[0];
        w_ix  = w_rnd[0];
        if (r_nan_p2) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_nan = 1'b1;
            w_uf  = 1'b0;
            w_ix  = 1'b0;
        end else if (r_inf_p2) begin
            w_res = {r_infs_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_uf  = 1'b0;
            w_ix  = 1'b0;
        end else if (r_sum_p2 == '0) begin
            w_res = {r_zs_p2, {(W-1){1'b0}}};
            w_uf  = 1'b0;
            w_ix  = 1'b0;
        end else if (!SUBN && w_tiny) begin
            w_res = {r_s_p2, {(W-1){1'b0}}};
            w_uf  = 1'b1;
            w_ix  = 1'b1;
        end else if (w_ovf) begin
            w_res = {r_s_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_of  = 1'b1;
            w_uf  = 1'b0;
            w_ix  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1       <= 1'b0;
            r_vld_p2       <= 1'b0;
            out_valid      <= 1'b0;
            result         <= '0;
            nan_flag       <= 1'b0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            inexact_flag   <= 1'b0;
        end else if (!w_stall) begin
            r_vld_p1  <= in_valid;
            r_vld_p2  <= r_vld_p1;
            out_valid <= r_vld_p2;
            if (r_vld_p2) begin
                result         <= w_res;
                nan_flag       <= w_nan;
                overflow_flag  <= w_of;
                underflow_flag <= w_uf;
                inexact_flag   <= w_ix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_s_p1    <= w_a_ge ? w_sa : w_sb;
            r_sub_p1  <= w_sa ^ w_sb;
            r_nan_p1  <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
            r_inf_p1  <= w_a_inf | w_b_inf;
            r_infs_p1 <= w_a_inf ? w_sa : w_sb;
            r_zs_p1   <= w_sa & w_sb;
            r_e_p1    <= w_xbig;
            r_mbig_p1 <= w_mbig;
            r_msml_p1 <= align(w_msml, w_sh1);

            r_s_p2    <= r_s_p1;
            r_nan_p2  <= r_nan_p1;
            r_inf_p2  <= r_inf_p1;
            r_infs_p2 <= r_infs_p1;
            r_zs_p2   <= r_zs_p1;
            r_e_p2    <= r_e_p1;
            r_sum_p2  <= w_sum;
        end
    end

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed bench for float_addsub_pipe (binary32): latency, arithmetic, specials, backpressure, reset.
module tb_float_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic        nan_flag, overflow_flag, underflow_flag, inexact_flag;
    logic [31:0] a, b, result;
    logic [3:0]  flags;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;
    assign flags = {nan_flag, overflow_flag, underflow_flag, inexact_flag};

    float_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .nan_flag(nan_flag), .overflow_flag(overflow_flag),
        .underflow_flag(underflow_flag), .inexact_flag(inexact_flag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic [31:0] rexp, input logic [3:0] fexp);
        int lat;
        @(negedge clk);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk(tag, 64'({result, flags}), 64'({rexp, fexp}));
    endtask

    logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000, 32'h4B800000, 32'h7F800000};
    logic [31:0] bp_b [6] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic        bp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] bp_r [6] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h40000000, 32'h4B800000, 32'h7F800000};
    logic [3:0]  bp_f [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};

    initial begin
        int nin, nout, cyc, extra, leaked;
        bit seen_low;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ov", 64'(out_valid), 64'd0);
        chk("reset_res", 64'({result, flags}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdy", 64'(in_ready), 64'd1);

        run_op("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
        run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8);
        run_op("nan_in", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8);
        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
        run_op("tie_even", 32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'h1);
        run_op("exact_zero", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
        run_op("neg_zero", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
        run_op("inf_fin", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0);
        run_op("three_m_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0);
        run_op("neg_result", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0);
        run_op("round_up", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1);
        run_op("tie_odd_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1);
`ifdef FADD_SUBNORMAL_EN
        run_op("subn_sub", 32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 4'h0);
        run_op("tiny", 32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'h0);
`else
        run_op("subn_sub", 32'h00800000, 32'h00400000, 1'b1, 32'h00800000, 4'h0);
        run_op("tiny", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3);
`endif

        nin = 0; nout = 0; cyc = 0; seen_low = 1'b0;
        while (nout < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc < 7);
            if (nin < 6) begin
                in_valid = 1'b1; a = bp_a[nin]; b = bp_b[nin]; sub = bp_s[nin];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) seen_low = 1'b1;
            if (in_valid && in_ready) nin++;
            if (out_valid)
                chk($sformatf("bp%0d", nout), 64'({result, flags}), 64'({bp_r[nout], bp_f[nout]}));
            if (out_valid && out_ready) nout++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", 64'(nout), 64'd6);
        chk("bp_issued", 64'(nin), 64'd6);
        chk("bp_ready_drop", 64'(seen_low), 64'd1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        chk("bp_extra", 64'(extra), 64'd0);

        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; sub = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ov", 64'(out_valid), 64'd0);
        chk("rst_mid_res", 64'({result, flags}), 64'd0);
        rst = 1'b0;
        leaked = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) leaked++;
        end
        chk("rst_mid_leak", 64'(leaked), 64'd0);
        chk("rst_mid_rdy", 64'(in_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float_addsub_pipe.md
Name: float_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754 adder/subtractor for the Vector ALU. Successor to the 32-bit combinational float adder.
- Adds runtime add/sub select, round-to-nearest-even, full special-case handling and status flags.
- Adds a valid/ready stream interface with backpressure.
- Sits between the VALU operand collector and result writeback. One op accepted per cycle, fixed 3-cycle latency.

Parameters:
EXP_W, 8, exponent field width (8 = binary32, 11 = binary64, 5 = binary16).
MAN_W, 23, stored fraction width (23 / 52 / 10).
Derived, not a parameter: W = 1+EXP_W+MAN_W.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  operands valid.
in_ready  out  1  block can accept this cycle.
a  in  W  operand A.
b  in  W  operand B.
sub  in  1  1: compute a-b (B sign inverted at stage 1); 0: a+b.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts.
result  out  W  IEEE result.
nan_flag  out  1  result is NaN (invalid op or NaN input).
overflow_flag  out  1  finite inputs rounded to infinity.
underflow_flag  out  1  nonzero result flushed / tiny.
inexact_flag  out  1  rounding discarded nonzero bits.

Behaviour:
- Reset: all stage valids 0; out_valid=0; result=0; all flags 0; in_ready=1 the cycle after rst deasserts. Reset mid-operation discards every in-flight op.
- Handshake:
  - Transfer on in_valid&in_ready and on out_valid&out_ready.
  - Whole pipe advances when stall = out_valid & !out_ready is 0.
  - in_ready = !stall. No combinational path from in_valid to in_ready.
  - result and flags hold stable while out_valid & !out_ready.
- Latency: op accepted in cycle N appears with out_valid=1 in cycle N+3 if no stall. Ops stay in order. Throughput is 1/cycle.
- Stage 1, unpack/align:
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Swap so the larger-magnitude operand is "big" (compare exponent, then fraction).
  - Subtract exponents. Right-shift the small significand into a MAN_W+4 bit field (hidden, fraction, guard, round, sticky). Shifted-out bits OR into sticky.
  - Shift amount saturates at MAN_W+3.
- Stage 2, add: effective subtract = sign_a ^ sign_b_eff. Add or subtract significands in MAN_W+5 bits. Result is never negative because of the swap.
- Stage 3, normalise/round:
  - On carry-out, shift right 1 and increment exponent. Otherwise leading-zero count and left shift, bounded so the exponent does not drop below 1.
  - Round to nearest, ties to even. Rounding carry renormalises.
  - Exponent reaching all-ones gives ±inf with overflow_flag=1 and inexact_flag=1.
- Special cases (override arithmetic, all flags except listed = 0):
  - Any NaN input: result = canonical quiet NaN {0, all-ones, 1, zeros}, nan_flag=1.
  - inf + (-inf) (after sub inversion): canonical NaN, nan_flag=1.
  - inf op finite: that infinity, no flags.
  - Exact zero sum: +0, except (-0)+(-0) = -0.
- Default subnormal policy is flush-to-zero. Subnormal inputs are treated as ±0. A result below min normal becomes ±0 with underflow_flag=1 and inexact_flag=1.

Optional Feature:
- Macro FADD_SUBNORMAL_EN.
- Defined: subnormal inputs use a hidden bit of 0 and an effective exponent of 1. Results below min normal are encoded as subnormals, rounded with RNE. underflow_flag=1 only when the result is tiny and inexact.
- Undefined: the flush-to-zero behaviour above. Latency is 3 in both builds.

Test Plan:
- Binary32 defaults, idle out_ready=1. Cycle 0: a=0x3F800000, b=0x40000000, sub=0 -> cycle 3: result=0x40400000, all flags 0.
- a=0x7F800000, b=0x7F800000, sub=1 -> result=0x7FC00000, nan_flag=1. a=0x7FC00001 + 1.0 -> 0x7FC00000, nan_flag=1.
- a=b=0x7F7FFFFF, sub=0 -> result=0x7F800000, overflow_flag=1, inexact_flag=1.
- a=0x4B800000 (2^24) + b=0x3F800000 (tie) -> result=0x4B800000, inexact_flag=1. a=0x3F800000 - 0x3F800000 -> 0x00000000.
- Backpressure and reset:
  - Issue 6 back-to-back ops with out_ready=0 from cycle 2 for 5 cycles -> in_ready drops once the pipe is full. No op lost or duplicated; outputs match in order after release.
  - Assert rst with 2 ops in flight -> out_valid=0 next cycle, and neither op appears.
- With FADD_SUBNORMAL_EN: 0x00800000 - 0x00400000 -> 0x00400000, no flags. Without it: 0x00800000 - 0x00400000 -> 0x00800000 (subnormal b flushed to zero), no flags.
